// File: rtl/ysyx_csr_file.sv
// Machine-mode CSR file: status/trap state, trap vectoring and the 64-bit cycle/instret counters.
// Reads are combinational on addr_i. Updates are arbitrated as irq_take > trap > mret > CSR write.
module ysyx_csr_file #(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MVENDORID_VAL = 32'h79737978,
    parameter logic [31:0] MARCHID_VAL   = 32'h015fde77,
    parameter int          HAS_COUNTERS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            wen_i,
    input  logic [11:0]     addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] cause_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            irq_timer_i,
    input  logic            irq_take_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] mepc_o
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    localparam bit              RV32       = (XLEN == 32);
    localparam bit              CNT_EN     = (HAS_COUNTERS != 0);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic            r_mie_mtie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;

    logic        w_we;
    logic [63:0] w_wdata64;
    logic [31:0] w_wd_hi;
    logic        w_cyc_wr_lo;
    logic        w_cyc_wr_hi;
    logic        w_ins_wr_lo;
    logic        w_ins_wr_hi;

    assign w_we      = valid_i & wen_i & ~illegal_o;
    assign w_wdata64 = 64'(wdata_i);
    // On RV32 the high-half CSRs carry their value in the low 32 bits of wdata_i.
    assign w_wd_hi   = RV32 ? w_wdata64[31:0] : w_wdata64[63:32];

    assign w_cyc_wr_lo = w_we & (addr_i == A_MCYCLE);
    assign w_cyc_wr_hi = w_we & (RV32 ? (addr_i == A_MCYCLEH) : (addr_i == A_MCYCLE));
    assign w_ins_wr_lo = w_we & (addr_i == A_MINSTRET);
    assign w_ins_wr_hi = w_we & (RV32 ? (addr_i == A_MINSTRETH) : (addr_i == A_MINSTRET));

    always_comb begin
        rdata_o   = '0;
        illegal_o = 1'b0;
        case (addr_i)
            A_MSTATUS: begin
                rdata_o[3]     = r_mstatus_mie;
                rdata_o[7]     = r_mstatus_mpie;
                rdata_o[12:11] = 2'b11;
            end
            A_MIE:       rdata_o[7] = r_mie_mtie;
            A_MTVEC:     rdata_o = r_mtvec;
            A_MSCRATCH:  rdata_o = r_mscratch;
            A_MEPC:      rdata_o = r_mepc;
            A_MCAUSE:    rdata_o = r_mcause;
            A_MIP: begin
                rdata_o[7] = irq_timer_i;
                illegal_o  = wen_i;
            end
            A_MCYCLE:    rdata_o = CNT_EN ? r_mcycle[XLEN-1:0] : '0;
            A_MINSTRET:  rdata_o = CNT_EN ? r_minstret[XLEN-1:0] : '0;
            A_MCYCLEH: begin
                if (RV32) rdata_o = CNT_EN ? XLEN'(r_mcycle[63:32]) : '0;
                else      illegal_o = 1'b1;
            end
            A_MINSTRETH: begin
                if (RV32) rdata_o = CNT_EN ? XLEN'(r_minstret[63:32]) : '0;
                else      illegal_o = 1'b1;
            end
            A_MVENDORID: begin
                rdata_o   = XLEN'(MVENDORID_VAL);
                illegal_o = wen_i;
            end
            A_MARCHID: begin
                rdata_o   = XLEN'(MARCHID_VAL);
                illegal_o = wen_i;
            end
            default:     illegal_o = 1'b1;
        endcase
    end

    assign irq_pending_o = r_mstatus_mie & r_mie_mtie & irq_timer_i;
    assign mepc_o        = r_mepc;
    // Vectored mode only offsets interrupts; the timer interrupt is cause 7.
    assign trap_vec_o    = (r_mtvec & ALIGN_MASK)
                         + (((r_mtvec[1:0] == 2'b01) && irq_pending_o) ? XLEN'(28) : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            if (w_we && addr_i == A_MTVEC)
                r_mtvec <= wdata_i[1] ? (wdata_i & ALIGN_MASK) : wdata_i;
            if (w_we && addr_i == A_MSCRATCH) r_mscratch <= wdata_i;
            if (w_we && addr_i == A_MIE)      r_mie_mtie <= wdata_i[7];

            if (irq_take_i) begin
                r_mepc         <= pc_i & ALIGN_MASK;
                r_mcause       <= IRQ_CAUSE;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (valid_i && trap_i) begin
                r_mepc         <= pc_i & ALIGN_MASK;
                r_mcause       <= cause_i;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (valid_i && mret_i) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_we && addr_i == A_MSTATUS) begin
                    r_mstatus_mie  <= wdata_i[3];
                    r_mstatus_mpie <= wdata_i[7];
                end
                if (w_we && addr_i == A_MEPC)   r_mepc   <= wdata_i & ALIGN_MASK;
                if (w_we && addr_i == A_MCAUSE) r_mcause <= wdata_i;
            end

            if (CNT_EN) begin
                // A write to either half freezes the whole counter for that edge.
                if (w_cyc_wr_lo || w_cyc_wr_hi)
                    r_mcycle <= {w_cyc_wr_hi ? w_wd_hi : r_mcycle[63:32],
                                 w_cyc_wr_lo ? w_wdata64[31:0] : r_mcycle[31:0]};
                else
                    r_mcycle <= r_mcycle + 64'd1;

                if (w_ins_wr_lo || w_ins_wr_hi)
                    r_minstret <= {w_ins_wr_hi ? w_wd_hi : r_minstret[63:32],
                                   w_ins_wr_lo ? w_wdata64[31:0] : r_minstret[31:0]};
                else if (retire_i)
                    r_minstret <= r_minstret + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_csr_file.sv
// Scoreboard bench for ysyx_csr_file (XLEN=32): expected values are queued as each
// stimulus step is driven and popped when the DUT output is sampled mid-cycle.
module tb_ysyx_csr_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 0, wen_i = 0, trap_i = 0, mret_i = 0, retire_i = 0;
    logic        irq_timer_i = 0, irq_take_i = 0;
    logic [11:0] addr_i = '0;
    logic [31:0] wdata_i = '0, cause_i = '0, pc_i = '0;
    logic [31:0] rdata_o, trap_vec_o, mepc_o;
    logic        illegal_o, irq_pending_o;

    ysyx_csr_file dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wen_i(wen_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .illegal_o(illegal_o), .trap_i(trap_i),
        .cause_i(cause_i), .pc_i(pc_i), .mret_i(mret_i), .retire_i(retire_i),
        .irq_timer_i(irq_timer_i), .irq_take_i(irq_take_i), .irq_pending_o(irq_pending_o),
        .trap_vec_o(trap_vec_o), .mepc_o(mepc_o)
    );

    always #10 clk = ~clk;

    typedef enum int { S_RDATA, S_ILLEGAL, S_PEND, S_TVEC, S_MEPC } sel_t;
    typedef struct { string tag; sel_t sel; logic [31:0] exp; } exp_t;
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(sel_t s);
        case (s)
            S_RDATA:   return rdata_o;
            S_ILLEGAL: return {31'd0, illegal_o};
            S_PEND:    return {31'd0, irq_pending_o};
            S_TVEC:    return trap_vec_o;
            default:   return mepc_o;
        endcase
    endfunction

    task automatic expect_obs(string tag, sel_t s, logic [11:0] a, logic [31:0] e);
        exp_t t;
        if (s == S_RDATA || s == S_ILLEGAL) addr_i = a;
        t.tag = tag; t.sel = s; t.exp = e;
        sb_q.push_back(t);
        #1;
        t = sb_q.pop_front();
        chk(t.tag, observe(t.sel), t.exp);
    endtask

    task automatic rd(string tag, logic [11:0] a, logic [31:0] e);
        expect_obs(tag, S_RDATA, a, e);
    endtask

    task automatic csr_wr(logic [11:0] a, logic [31:0] d);
        @(negedge clk);
        valid_i = 1; wen_i = 1; addr_i = a; wdata_i = d;
        @(negedge clk);
        valid_i = 0; wen_i = 0;
    endtask

    initial begin
        // reset held: state is zero, mstatus still shows MPP=11
        #3;
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec",   12'h305, 32'h0);
        rd("rst_mcycle",  12'hB00, 32'h0);
        expect_obs("rst_tvec", S_TVEC, 12'h0, 32'h0);
        expect_obs("rst_illegal_unimpl", S_ILLEGAL, 12'h123, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rd("cycle_after_release", 12'hB00, 32'h1);
        rd("marchid", 12'hF12, 32'h015f_de77);

        // mtvec WARL mode
        csr_wr(12'h305, 32'h8000_0101);
        rd("mtvec_mode1", 12'h305, 32'h8000_0101);
        csr_wr(12'h305, 32'h8000_0103);
        rd("mtvec_mode3", 12'h305, 32'h8000_0100);

        // trap entry then mret
        csr_wr(12'h300, 32'h0000_0008);
        rd("mstatus_mie_set", 12'h300, 32'h0000_1808);
        @(negedge clk);
        valid_i = 1; trap_i = 1; pc_i = 32'h8000_0012; cause_i = 32'd11;
        @(negedge clk);
        valid_i = 0; trap_i = 0;
        rd("trap_mepc", 12'h341, 32'h8000_0010);
        rd("trap_mcause", 12'h341 + 12'h1, 32'd11);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        expect_obs("trap_mepc_o", S_MEPC, 12'h0, 32'h8000_0010);
        @(negedge clk);
        valid_i = 1; mret_i = 1;
        @(negedge clk);
        valid_i = 0; mret_i = 0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // timer interrupt, vectored
        csr_wr(12'h305, 32'h8000_0001);
        csr_wr(12'h304, 32'h0000_0080);
        irq_timer_i = 1;
        #1;
        expect_obs("irq_pending", S_PEND, 12'h0, 32'h1);
        expect_obs("irq_tvec", S_TVEC, 12'h0, 32'h8000_001C);
        rd("mip_mtip", 12'h344, 32'h0000_0080);
        @(negedge clk);
        irq_take_i = 1; pc_i = 32'h8000_0044;
        @(negedge clk);
        irq_take_i = 0;
        rd("irq_mcause", 12'h342, 32'h8000_0007);
        rd("irq_mepc", 12'h341, 32'h8000_0044);
        expect_obs("irq_pending_clr", S_PEND, 12'h0, 32'h0);
        expect_obs("irq_tvec_base", S_TVEC, 12'h0, 32'h8000_0000);
        irq_timer_i = 0;

        // same-cycle priority: irq_take beats trap; trap beats a CSR write to mepc
        @(negedge clk);
        valid_i = 1; trap_i = 1; irq_take_i = 1; cause_i = 32'd2; pc_i = 32'h8000_0100;
        @(negedge clk);
        trap_i = 0; irq_take_i = 0; valid_i = 0;
        rd("prio_irq_cause", 12'h342, 32'h8000_0007);
        @(negedge clk);
        valid_i = 1; trap_i = 1; wen_i = 1; addr_i = 12'h341; wdata_i = 32'h0000_1234;
        cause_i = 32'd3; pc_i = 32'h8000_0200;
        @(negedge clk);
        valid_i = 0; trap_i = 0; wen_i = 0;
        rd("prio_trap_mepc", 12'h341, 32'h8000_0200);
        csr_wr(12'h341, 32'h0000_1237);
        rd("mepc_wr_align", 12'h341, 32'h0000_1234);

        // counter carry and write/increment collision
        csr_wr(12'hB80, 32'h0);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_written", 12'hB80, 32'h0);
        @(negedge clk);
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);
        csr_wr(12'hB00, 32'h0000_0100);
        rd("mcycle_held", 12'hB00, 32'h0000_0100);
        rd("mcycleh_kept", 12'hB80, 32'h1);
        @(negedge clk);
        rd("mcycle_resume", 12'hB00, 32'h0000_0101);

        @(negedge clk);
        valid_i = 1; wen_i = 1; addr_i = 12'hB02; wdata_i = 32'd5; retire_i = 1;
        @(negedge clk);
        valid_i = 0; wen_i = 0;
        rd("minstret_wr_wins", 12'hB02, 32'd5);
        @(negedge clk);
        rd("minstret_retire", 12'hB02, 32'd6);
        retire_i = 0;
        @(negedge clk);
        rd("minstret_idle", 12'hB02, 32'd6);
        rd("minstreth", 12'hB82, 32'd0);

        // read-only and unimplemented
        @(negedge clk);
        valid_i = 1; wen_i = 1; addr_i = 12'hF11; wdata_i = 32'h0;
        #1;
        expect_obs("ro_wr_illegal", S_ILLEGAL, 12'hF11, 32'h1);
        @(negedge clk);
        addr_i = 12'h344;
        #1;
        expect_obs("mip_wr_illegal", S_ILLEGAL, 12'h344, 32'h1);
        @(negedge clk);
        valid_i = 0; wen_i = 0;
        rd("mvendorid_kept", 12'hF11, 32'h7973_7978);
        expect_obs("mvendorid_rd_legal", S_ILLEGAL, 12'hF11, 32'h0);
        rd("unimpl_zero", 12'h7C0, 32'h0);

        // asynchronous reset mid-cycle
        csr_wr(12'h340, 32'hDEAD_BEEF);
        rd("mscratch", 12'h340, 32'hDEAD_BEEF);
        #3;
        rst = 1;
        #1;
        rd("arst_mscratch", 12'h340, 32'h0);
        rd("arst_mtvec", 12'h305, 32'h0);
        rd("arst_mcycle", 12'hB00, 32'h0);
        rd("arst_mie", 12'h304, 32'h0);
        expect_obs("arst_mepc_o", S_MEPC, 12'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_csr_file.md
YSYX_CSR_FILE -- requirements
Module: ysyx_csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of every CSR port (32 or 64).
REQ-002 SHALL have parameter MVENDORID_VAL, default 32'h79737978, meaning mvendorid read value.
REQ-003 SHALL have parameter MARCHID_VAL, default 32'h015fde77, meaning marchid read value.
REQ-004 SHALL have parameter HAS_COUNTERS, default 1, meaning mcycle/minstret implemented; 0 ties them to zero.
REQ-005 SHALL have ports, in order:
 clk  in  1  clock, one clock domain;
 rst  in  1  asynchronous active-high reset;
 valid_i  in  1  EXU instruction valid this cycle;
 wen_i  in  1  CSR write request (qualified by valid_i);
 addr_i  in  12  CSR address for read and write;
 wdata_i  in  XLEN  write data;
 rdata_o  out  XLEN  combinational read data for addr_i;
 illegal_o  out  1  addr_i unimplemented, or wen_i to read-only CSR;
 trap_i  in  1  synchronous exception/ecall entry (qualified by valid_i);
 cause_i  in  XLEN  exception code for trap_i;
 pc_i  in  XLEN  PC of trapping instruction;
 mret_i  in  1  mret executed (qualified by valid_i);
 retire_i  in  1  instruction retired this cycle;
 irq_timer_i  in  1  level timer interrupt request;
 irq_take_i  in  1  core takes pending interrupt this cycle;
 irq_pending_o  out  1  interrupt enabled and pending;
 trap_vec_o  out  XLEN  next-PC target for trap/interrupt;
 mepc_o  out  XLEN  current mepc.

Function
REQ-006 SHALL implement mstatus(0x300: MIE bit3, MPIE bit7, MPP bits12:11), mie(0x304: MTIE bit7), mtvec(0x305), mscratch(0x340), mepc(0x341), mcause(0x342), mip(0x344: MTIP bit7), mcycle(0xB00), minstret(0xB02), mvendorid(0xF11), marchid(0xF12); for XLEN=32 also mcycleh(0xB80), minstreth(0xB82).
REQ-007 SHALL return rdata_o combinationally; unimplemented address reads 0 and asserts illegal_o.
REQ-008 SHALL assert illegal_o when wen_i targets 0xF11, 0xF12 or 0x344; such writes SHALL not modify state.
REQ-009 SHALL commit writes on the clock edge when valid_i&wen_i&!illegal_o; mepc bits[1:0] forced 0; mtvec mode bits[1:0] WARL, value 2 or 3 stored as 0; MPP always reads 2'b11; unlisted mstatus bits read 0.
REQ-010 SHALL, on valid_i&trap_i: mepc<=pc_i&~3, mcause<=cause_i, MPIE<=MIE, MIE<=0, in one cycle.
REQ-011 SHALL, on irq_take_i: mepc<=pc_i&~3, mcause<={1'b1, (XLEN-1)'d7}, MPIE<=MIE, MIE<=0.
REQ-012 SHALL, on valid_i&mret_i: MIE<=MPIE, MPIE<=1.
REQ-013 SHALL prioritise same-cycle events: irq_take_i > trap_i > mret_i > CSR write; a lower-priority event's updates to any register written by a higher one are dropped.
REQ-014 SHALL drive trap_vec_o = {mtvec[XLEN-1:2],2'b00}, plus 4*7 when mode=1 and irq_pending_o; combinational.
REQ-015 SHALL mirror mip.MTIP = irq_timer_i combinationally; irq_pending_o = MIE & MTIE & irq_timer_i.
REQ-016 SHALL increment 64-bit mcycle every cycle and minstret when retire_i, wrapping 2^64-1 -> 0.
REQ-017 SHALL, when a CSR write targets a counter half in the same cycle as its increment, store wdata_i in that half and increment neither half that cycle.
REQ-018 SHALL, for XLEN=32, carry low-half overflow into the high half in the same edge.
REQ-019 SHALL read mcycle/minstret/h as 0 and ignore writes when HAS_COUNTERS=0.

Reset
REQ-020 SHALL, on rst asserted, asynchronously clear mstatus (MIE=MPIE=0), mie, mtvec, mscratch, mepc, mcause, mcycle, minstret to 0; outputs settle to rdata_o per addr_i, illegal_o per addr_i, irq_pending_o=0, trap_vec_o=0, mepc_o=0.
REQ-021 SHALL ignore all inputs while rst high; counters resume from 0 the first edge after release.

Verification
REQ-022 Write mtvec=0x80000101, read -> 0x80000101; write 0x80000103 -> reads 0x80000100.
REQ-023 MIE=1, trap_i with pc_i=0x80000012, cause_i=11 -> mepc=0x80000010, mcause=11, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-024 mtvec=0x80000001, MIE=1, MTIE=1, irq_timer_i=1 -> irq_pending_o=1, trap_vec_o=0x8000001C; irq_take_i -> mcause=0x80000007, irq_pending_o=0.
REQ-025 XLEN=32: write mcycle=0xFFFFFFFF, mcycleh=0 -> next cycle mcycle=0, mcycleh=1; write mcycle concurrent with increment -> written value held one cycle.
REQ-026 Write 0xF11 -> illegal_o=1, mvendorid still 0x79737978; rst asserted mid-sequence -> all CSRs 0 without a clock edge.
